seg_pipe_addsub: RTL and testbench



---
 rtl/seg_pipe_addsub.sv | 122 ++++++++++++
 tb/tb_seg_pipe_addsub.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pipe_addsub.sv
// rtl/seg_pipe_addsub.sv - segmented-carry pipelined add/sub with valid/ready; clamp on overflow via SEG_PIPE_ADDSUB_SAT_EN
module seg_pipe_addsub #(
    parameter int WIDTH = 24,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_cond;
    logic             w_c0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_b_cond = b ^ {WIDTH{sub}};
    assign w_c0     = cin ^ sub;

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : g_stg
            localparam int LO = k * SEG;
            localparam int UW = WIDTH - LO - SEG;

            // w_ua/w_ub: operand bits from this stage's segment up to the MSB
            logic [WIDTH-LO-1:0] w_ua;
            logic [WIDTH-LO-1:0] w_ub;
            logic                w_ci;
            logic                w_vi;
            logic [SEG:0]        w_seg;
            logic [LO+SEG-1:0]   w_snext;
            logic [LO+SEG-1:0]   w_sd;
            logic                r_v;
            logic                r_c;
            logic [LO+SEG-1:0]   r_s;

            if (k == 0) begin : g_src
                assign w_ua    = a;
                assign w_ub    = w_b_cond;
                assign w_ci    = w_c0;
                assign w_vi    = in_valid;
                assign w_snext = w_seg[SEG-1:0];
            end else begin : g_src
                assign w_ua    = g_stg[k-1].g_up.r_a;
                assign w_ub    = g_stg[k-1].g_up.r_b;
                assign w_ci    = g_stg[k-1].r_c;
                assign w_vi    = g_stg[k-1].r_v;
                assign w_snext = {w_seg[SEG-1:0], g_stg[k-1].r_s};
            end

            assign w_seg = {1'b0, w_ua[SEG-1:0]} + {1'b0, w_ub[SEG-1:0]} + {{SEG{1'b0}}, w_ci};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_s <= '0;
                end else if (w_adv) begin
                    r_v <= w_vi;
                    r_c <= w_seg[SEG];
                    r_s <= w_sd;
                end
            end

            if (k < NSEG - 1) begin : g_up
                logic [UW-1:0] r_a;
                logic [UW-1:0] r_b;

                assign w_sd = w_snext;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_adv) begin
                        r_a <= w_ua[WIDTH-LO-1:SEG];
                        r_b <= w_ub[WIDTH-LO-1:SEG];
                    end
                end
            end else begin : g_last
                logic w_ovf;
                logic r_ovf;

                // operand signs arrive as the top bit of the last segment
                assign w_ovf = (w_ua[SEG-1] == w_ub[SEG-1]) && (w_seg[SEG-1] != w_ua[SEG-1]);

`ifdef SEG_PIPE_ADDSUB_SAT_EN
                assign w_sd = !w_ovf ? w_snext :
                              (w_ua[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
                assign w_sd = w_snext;
`endif

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_ovf <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf <= w_ovf;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stg[NSEG-1].r_v;
    assign sum       = g_stg[NSEG-1].r_s;
    assign cout      = g_stg[NSEG-1].r_c;
    assign ovf       = g_stg[NSEG-1].g_last.r_ovf;

endmodule

// File: tb/tb_seg_pipe_addsub.sv
// tb/tb_seg_pipe_addsub.sv - randomized scoreboard bench for seg_pipe_addsub
module tb_seg_pipe_addsub;
    localparam int     W    = 24;
    localparam int     SEG  = 8;
    localparam int     NSEG = W / SEG;
    localparam longint MAXS = longint'(2**(W-1)) - 1;
    localparam longint MINS = -longint'(2**(W-1));

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_run;
    int n_fail;
    int cyc;
    int stall_cnt;
    int stall_left;
    bit rand_rdy;

    logic [W+1:0] exp_q[$];
    int           acc_cyc_q[$];
    int           acc_stall_q[$];

    bit           hold_v;
    logic [W+1:0] hold_val;

    seg_pipe_addsub #(.WIDTH(W), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Result from signed/unsigned integer arithmetic: {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                           input logic fsub, input logic fcin);
        longint       sa, sb, ua, ub, tr;
        logic         co, ov;
        logic [W-1:0] s;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        ua = longint'(fa);
        ub = longint'(fb);
        if (!fsub) begin
            tr = sa + sb + longint'(fcin);
            co = (ua + ub + longint'(fcin)) >= (longint'(1) << W);
        end else begin
            tr = sa - sb - longint'(fcin);
            co = !(ua < ub + longint'(fcin));
        end
        ov = (tr > MAXS) || (tr < MINS);
        s  = tr[W-1:0];
`ifdef SEG_PIPE_ADDSUB_SAT_EN
        if (ov) s = (tr > MAXS) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        return {ov, co, s};
    endfunction

    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (rand_rdy) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Scoreboard: sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, (!out_valid || out_ready));
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {ovf, cout, sum}, hold_val);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    logic [W+1:0] e;
                    int           ac, ast;
                    e   = exp_q.pop_front();
                    ac  = acc_cyc_q.pop_front();
                    ast = acc_stall_q.pop_front();
                    chk("sum", sum, e[W-1:0]);
                    chk("cout", cout, e[W]);
                    chk("ovf", ovf, e[W+1]);
                    chk("latency", cyc - ac, NSEG + (stall_cnt - ast));
                end
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                hold_v   = 1'b1;
                hold_val = {ovf, cout, sum};
            end else begin
                hold_v = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub, cin));
                acc_cyc_q.push_back(cyc);
                acc_stall_q.push_back(stall_cnt);
            end
        end
    end

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs, input logic vc);
        int n;
        a        = va;
        b        = vb;
        sub      = vs;
        cin      = vc;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return {1'b0, {(W-1){1'b1}}};
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return {W{1'b1}};
            3:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    logic [W-1:0] va[7];
    logic [W-1:0] vb[7];
    logic         vs[7];
    logic         vc[7];
    logic [W+1:0] ve[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_run = 0; n_fail = 0; cyc = 0; stall_cnt = 0; stall_left = 0;
        rand_rdy = 1'b0; hold_v = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;

        va[0] = 24'h000005; vb[0] = 24'h000003; vs[0] = 0; vc[0] = 0; ve[0] = {1'b0, 1'b0, 24'h000008};
        va[1] = 24'h00FFFF; vb[1] = 24'h000001; vs[1] = 0; vc[1] = 1; ve[1] = {1'b0, 1'b0, 24'h010001};
        va[2] = 24'hFFFFFF; vb[2] = 24'h000001; vs[2] = 0; vc[2] = 0; ve[2] = {1'b0, 1'b1, 24'h000000};
        va[3] = 24'h000010; vb[3] = 24'h000020; vs[3] = 1; vc[3] = 0; ve[3] = {1'b0, 1'b0, 24'hFFFFF0};
        va[4] = 24'h000010; vb[4] = 24'h000020; vs[4] = 1; vc[4] = 1; ve[4] = {1'b0, 1'b0, 24'hFFFFEF};
        va[5] = 24'h7FFFFF; vb[5] = 24'h000001; vs[5] = 0; vc[5] = 0;
        va[6] = 24'h800000; vb[6] = 24'h000001; vs[6] = 1; vc[6] = 0;
`ifdef SEG_PIPE_ADDSUB_SAT_EN
        ve[5] = {1'b1, 1'b0, 24'h7FFFFF};
        ve[6] = {1'b1, 1'b1, 24'h800000};
`else
        ve[5] = {1'b1, 1'b0, 24'h800000};
        ve[6] = {1'b1, 1'b1, 24'h7FFFFF};
`endif

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        idle(3);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed vectors, each on an empty pipe so latency is exactly NSEG
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("model_pin%0d", i), model(va[i], vb[i], vs[i], vc[i]), ve[i]);
            send(va[i], vb[i], vs[i], vc[i]);
            idle(NSEG + 2);
        end
        drain();

        // Back-pressure: six back-to-back beats, output stalled 4 cycles mid-stream
        for (int i = 0; i < 6; i++) begin
            send(W'(24'h100 * (i + 1)), W'(i * 3 + 1), i[0], i[1]);
            if (i == 3) stall_left = 4;
        end
        drain();

        // Asynchronous reset with three beats in flight
        for (int i = 0; i < 3; i++) send(W'(24'h010000 + i), W'(24'h000011), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        acc_stall_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(NSEG + 2);
        send(24'h123456, 24'h000111, 1'b0, 1'b1);
        drain();

        // Random traffic with bubbles and random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
